// File: rtl/alarm_ctrl.sv
// Alarm life-cycle sequencer: arms on a minute match, rings with a 1 Hz buzzer
// pattern, supports a bounded number of snoozes, and blocks re-trigger until match drops.
module alarm_ctrl #(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       alarm_arm,
    input  logic       match,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_left
);

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE,
        DONE
    } state_e;

    localparam logic [9:0] RING_LAST   = 10'(RING_SEC - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);
    localparam logic [1:0] MAX_SNZ     = 2'(MAX_SNOOZE);

    state_e     state_q, state_d;
    logic [9:0] timer_q, timer_d;
    logic [1:0] snz_q, snz_d;
    logic       beep_q, beep_d;

    logic       buzzer_q, ringing_q, snoozing_q;
    logic [1:0] snooze_left_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        snz_d   = snz_q;
        beep_d  = beep_q;
        case (state_q)
            IDLE: begin
                snz_d = '0;
                if (alarm_arm && match) begin
                    state_d = RING;
                    timer_d = '0;
                    beep_d  = 1'b1;
                end
            end
            RING: begin
                // A snooze request with no snoozes left falls through to tick handling
                if (!alarm_arm || key_stop) begin
                    state_d = DONE;
                end else if (key_snooze && (snz_q < MAX_SNZ)) begin
                    state_d = SNOOZE;
                    snz_d   = snz_q + 2'd1;
                    timer_d = '0;
                end else if (tick_1hz) begin
                    beep_d = ~beep_q;
                    if (timer_q == RING_LAST) begin
                        state_d = DONE;
                    end else begin
                        timer_d = timer_q + 10'd1;
                    end
                end
            end
            SNOOZE: begin
                if (!alarm_arm || key_stop) begin
                    state_d = DONE;
                end else if (tick_1hz) begin
                    if (timer_q == SNOOZE_LAST) begin
                        state_d = RING;
                        timer_d = '0;
                        beep_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 10'd1;
                    end
                end
            end
            DONE: begin
                if (!match) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Snooze budget is restored as soon as the alarm event is over
        if (state_d == DONE) begin
            snz_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            snz_q         <= '0;
            beep_q        <= 1'b0;
            buzzer_q      <= 1'b0;
            ringing_q     <= 1'b0;
            snoozing_q    <= 1'b0;
            snooze_left_q <= MAX_SNZ;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            snz_q         <= snz_d;
            beep_q        <= beep_d;
            buzzer_q      <= (state_d == RING) && beep_d;
            ringing_q     <= (state_d == RING);
            snoozing_q    <= (state_d == SNOOZE);
            snooze_left_q <= MAX_SNZ - snz_d;
        end
    end

    assign buzzer      = buzzer_q;
    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;
    assign snooze_left = snooze_left_q;

endmodule
